fetch_pc_unit: RTL

Instruction-fetch stage that owns the program counter, drives the instruction-memory request, and presents one fetched instruction at a time to decode. It consumes the 32-bit jump target produced by the jump-address stage, i.e. {pc_plus4[31:28], inst[25:0], 2'b00}, plus a branch target. It supplies `pc_plus4` back to that stage. At most one memory request is outstanding; redirects squash in-flight fetches.

---
 rtl/fetch_pc_unit_if.sv | 10 +
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request bus between the fetch stage (master) and memory (slave).
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues one outstanding imem request, squashes on redirect.
// Optional macro FETCH_ALIGN_CHECK_EN: force redirect targets word-aligned and pulse align_err.
//
// state | meaning
// IDLE  | after reset, request not yet issued
// REQ   | imem_req high, waiting for imem_ack
// VALID | instruction presented to decode
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_pc_unit_if.master        imem,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [31:0]            jump_target,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  output logic [31:0]            inst_out,
  output logic                   inst_valid,
  output logic [31:0]            fetch_pc,
  output logic [31:0]            pc_plus4,
  output logic                   align_err
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  state_t      state, state_d;
  logic [31:0] addr_q, addr_d;
  logic        squash_q, squash_d;
  logic [31:0] squash_tgt_q, squash_tgt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        misaligned;

  assign redirect   = jump_en | branch_taken;
  assign target_raw = jump_en ? jump_target : branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = {target_raw[31:2], 2'b00};
  assign misaligned = |target_raw[1:0];
`else
  assign target     = target_raw;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= RESET_VECTOR;
      squash_q     <= 1'b0;
      squash_tgt_q <= RESET_VECTOR;
      inst_q       <= 32'h0;
      pc_q         <= RESET_VECTOR;
      err_q        <= 1'b0;
    end else begin
      state        <= state_d;
      addr_q       <= addr_d;
      squash_q     <= squash_d;
      squash_tgt_q <= squash_tgt_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    squash_d     = squash_q;
    squash_tgt_d = squash_tgt_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    err_d        = 1'b0;
    unique case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          if (squash_q || redirect) begin
            // stale word dropped; reissue at the newest target
            addr_d   = redirect ? target : squash_tgt_q;
            squash_d = 1'b0;
            err_d    = redirect & misaligned;
          end else begin
            inst_d  = imem.imem_rdata;
            pc_d    = addr_q;
            state_d = VALID;
          end
        end else if (redirect) begin
          squash_d     = 1'b1;
          squash_tgt_d = target;
          err_d        = misaligned;
        end
      end
      VALID: begin
        if (redirect) begin
          addr_d  = target;
          err_d   = misaligned;
          state_d = REQ;
        end else if (!stall) begin
          addr_d  = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = addr_q;
  assign inst_out       = inst_q;
  assign inst_valid     = (state == VALID);
  assign fetch_pc       = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign align_err      = err_q;

endmodule
